dm_access_ctrl: RTL and testbench

//   Sequences the single data-memory port and shares it between the CPU MEM stage and a DMA/debug requester.

---
 rtl/dm_access_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
//   Sequences the single data-memory port and shares it between the CPU MEM
//   stage and a DMA/debug requester. Builds byte enables and lane-replicated
//   write data for word/half/byte stores and stalls the CPU until its access
//   completes.
//
//   Handshakes: a requester raises *_req with its controls and holds them
//   until it sees the one-cycle *_done pulse. mem_req is held high with stable
//   mem_* controls until mem_ack is sampled high on a rising clock edge, or
//   until the timeout aborts the access.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cpu_req/we/size/addr/wdata  CPU access request (size 000 W, 001 H, 010 B)
//   cpu_stall                   cpu_req & ~cpu_done
//   cpu_done/err/rdata          CPU completion pulse, error flag, raw mem word
//   dma_req/we/addr/wdata       DMA word access request
//   dma_done/err/rdata          DMA completion pulse, timeout flag, read word
//   mem_req/we/addr/be/wdata    data-memory request side
//   mem_rdata/ack               data-memory response side
//   state_dbg                   current FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_done,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  state_dbg
);

  localparam int FW = $clog2(FAIR_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state, state_next;
  logic          owner;        // 0 = CPU, 1 = DMA
  logic          l_we;
  logic [2:0]    l_size;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          err_r;
  logic [31:0]   rdata_r;
  logic [FW-1:0] fair_cnt;
  logic [TW-1:0] to_cnt;

  logic cpu_win, dma_win, cpu_legal, to_last;

  // CPU keeps priority until it has taken FAIR_LIMIT grants in a row while
  // the DMA was waiting.
  assign cpu_win = (state == IDLE) && cpu_req &&
                   !(dma_req && (fair_cnt == FW'(FAIR_LIMIT)));
  assign dma_win = (state == IDLE) && dma_req && !cpu_win;
  assign to_last = (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    case (cpu_size)
      3'b000:  cpu_legal = (cpu_addr[1:0] == 2'b00);
      3'b001:  cpu_legal = !cpu_addr[0];
      3'b010:  cpu_legal = 1'b1;
      default: cpu_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // An illegal CPU access skips the memory entirely.
        if (cpu_win)      state_next = cpu_legal ? BUSY : RESP;
        else if (dma_win) state_next = BUSY;
      end
      BUSY:    if (mem_ack || to_last) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched access, fairness and timeout bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      l_we     <= 1'b0;
      l_size   <= 3'b000;
      l_addr   <= 32'h0;
      l_wdata  <= 32'h0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0;
      fair_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (cpu_win) begin
        owner    <= 1'b0;
        l_we     <= cpu_we;
        l_size   <= cpu_size;
        l_addr   <= cpu_addr;
        l_wdata  <= cpu_wdata;
        err_r    <= !cpu_legal;
        to_cnt   <= '0;
        fair_cnt <= dma_req ? fair_cnt + FW'(1) : '0;
      end else if (dma_win) begin
        owner    <= 1'b1;
        l_we     <= dma_we;
        l_size   <= 3'b000;    // DMA is always a full word
        l_addr   <= dma_addr;
        l_wdata  <= dma_wdata;
        err_r    <= 1'b0;
        to_cnt   <= '0;
        fair_cnt <= '0;
      end
      if (state == BUSY) begin
        if (mem_ack) begin
          rdata_r <= mem_rdata;
          err_r   <= 1'b0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
          if (to_last) err_r <= 1'b1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    cpu_done  = (state == RESP) && !owner;
    dma_done  = (state == RESP) && owner;
    cpu_err   = cpu_done && err_r;
    dma_err   = dma_done && err_r;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (state == BUSY) begin
      mem_req  = 1'b1;
      mem_we   = l_we;
      mem_addr = {l_addr[31:2], 2'b00};
      case (l_size)
        3'b001: begin
          mem_be    = l_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{l_wdata[15:0]}};
        end
        3'b010: begin
          mem_be    = 4'b0001 << l_addr[1:0];
          mem_wdata = {4{l_wdata[7:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = l_wdata;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req && !cpu_done;
  assign cpu_rdata = rdata_r;
  assign dma_rdata = rdata_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
//   Directed bench for dm_access_ctrl. Stimulus pushes expected memory
//   requests and completion responses into queues; a negedge monitor pops and
//   compares whenever the DUT raises mem_req or a done pulse.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_size = 3'b000;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0;
  logic        dma_done, dma_err;
  logic [31:0] dma_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [1:0]  state_dbg;

  dm_access_ctrl #(.FAIR_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;
  logic [31:0] rd_word = 32'h0;

  always @(negedge clk) begin
    mem_ack   = mem_req && (ack_en || force_ack);
    mem_rdata = mem_ack ? rd_word : 32'h0;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [7:0]  lat;      // 0 = latency not checked
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        chk_wd;
    logic [31:0] wdata;
  } mreq_t;

  rsp_t  cpu_exp_q[$];
  rsp_t  dma_exp_q[$];
  mreq_t mem_exp_q[$];
  int    len_exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cpu_start = 0;
  int dma_start = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic exp_cpu(input logic err, input logic chk, input logic [31:0] rd, input logic [7:0] lat);
    cpu_exp_q.push_back('{err: err, chk_rd: chk, rdata: rd, lat: lat});
  endtask

  task automatic exp_dma(input logic err, input logic chk, input logic [31:0] rd, input logic [7:0] lat);
    dma_exp_q.push_back('{err: err, chk_rd: chk, rdata: rd, lat: lat});
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic chk, input logic [31:0] wd, input int len);
    mem_exp_q.push_back('{we: we, addr: addr, be: be, chk_wd: chk, wdata: wd});
    len_exp_q.push_back(len);
  endtask

  // ---------------- monitor ----------------
  rsp_t  mon_r;
  mreq_t mon_m;
  logic  prev_req = 1'b0;
  int    run_len = 0;
  int    exp_len;

  always @(negedge clk) begin
    if (cpu_done === 1'b1) begin
      if (cpu_exp_q.size() == 0) unexpected("cpu_done");
      else begin
        mon_r = cpu_exp_q.pop_front();
        check("cpu_err", 64'(cpu_err), 64'(mon_r.err));
        check("cpu_stall_at_done", 64'(cpu_stall), 64'(0));
        if (mon_r.chk_rd) check("cpu_rdata", 64'(cpu_rdata), 64'(mon_r.rdata));
        if (mon_r.lat != 0) check("cpu_latency", 64'(cyc - cpu_start), 64'(mon_r.lat));
      end
    end
    if (dma_done === 1'b1) begin
      if (dma_exp_q.size() == 0) unexpected("dma_done");
      else begin
        mon_r = dma_exp_q.pop_front();
        check("dma_err", 64'(dma_err), 64'(mon_r.err));
        if (mon_r.chk_rd) check("dma_rdata", 64'(dma_rdata), 64'(mon_r.rdata));
        if (mon_r.lat != 0) check("dma_latency", 64'(cyc - dma_start), 64'(mon_r.lat));
      end
    end
    if (mem_req === 1'b1) begin
      if (!prev_req) begin
        run_len = 0;
        if (mem_exp_q.size() == 0) unexpected("mem_req");
        else begin
          mon_m = mem_exp_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(mon_m.we));
          check("mem_addr", 64'(mem_addr), 64'(mon_m.addr));
          check("mem_be", 64'(mem_be), 64'(mon_m.be));
          if (mon_m.chk_wd) check("mem_wdata", 64'(mem_wdata), 64'(mon_m.wdata));
        end
      end
      run_len++;
    end else if (prev_req) begin
      if (len_exp_q.size() == 0) unexpected("mem_req_len");
      else begin
        exp_len = len_exp_q.pop_front();
        check("mem_req_cycles", 64'(run_len), 64'(exp_len));
      end
    end
    prev_req = (mem_req === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cpu_done();
    bit seen = 0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      if (cpu_done === 1'b1) seen = 1;
      else check("cpu_stall_wait", 64'(cpu_stall), 64'(1));
    end
    if (!seen) unexpected("cpu_done_timeout");
  endtask

  task automatic wait_dma_done();
    bit seen = 0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      if (dma_done === 1'b1) seen = 1;
    end
    if (!seen) unexpected("dma_done_timeout");
  endtask

  task automatic cpu_seq(input int n, input logic we_i, input logic [2:0] sz,
                         input logic [31:0] a0, input logic [31:0] step, input logic [31:0] d0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      cpu_req   = 1'b1;
      cpu_we    = we_i;
      cpu_size  = sz;
      cpu_addr  = a0 + step * 32'(i);
      cpu_wdata = d0 + 32'(i);
      cpu_start = cyc;
      wait_cpu_done();
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic dma_seq(input int n, input logic we_i, input logic [31:0] a0,
                         input logic [31:0] step, input logic [31:0] d0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      dma_req   = 1'b1;
      dma_we    = we_i;
      dma_addr  = a0 + step * 32'(i);
      dma_wdata = d0 + 32'(i);
      dma_start = cyc;
      wait_dma_done();
      @(posedge clk); #1;
    end
    dma_req = 1'b0;
    dma_we  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_be", 64'(mem_be), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_cpu_done", 64'(cpu_done), 64'(0));
    check("rst_dma_done", 64'(dma_done), 64'(0));
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // byte store to lane 3, byte load from lane 1
    rd_word = 32'h1122_3344;
    exp_mem(1'b1, 32'h100, 4'b1000, 1'b1, 32'hABAB_ABAB, 1);
    exp_cpu(1'b0, 1'b1, 32'h1122_3344, 8'd2);
    cpu_seq(1, 1'b1, 3'b010, 32'h103, 32'h0, 32'h0000_00AB);

    rd_word = 32'hA5A5_0F0F;
    exp_mem(1'b0, 32'h100, 4'b0010, 1'b0, 32'h0, 1);
    exp_cpu(1'b0, 1'b1, 32'hA5A5_0F0F, 8'd2);
    cpu_seq(1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0);

    // word store, half stores/loads on both halves
    rd_word = 32'h0;
    exp_mem(1'b1, 32'h208, 4'b1111, 1'b1, 32'hCAFE_F00D, 1);
    exp_cpu(1'b0, 1'b1, 32'h0, 8'd2);
    cpu_seq(1, 1'b1, 3'b000, 32'h208, 32'h0, 32'hCAFE_F00D);

    exp_mem(1'b1, 32'h200, 4'b0011, 1'b1, 32'h1234_1234, 1);
    exp_cpu(1'b0, 1'b0, 32'h0, 8'd2);
    cpu_seq(1, 1'b1, 3'b001, 32'h200, 32'h0, 32'h0000_1234);

    rd_word = 32'h8765_4321;
    exp_mem(1'b0, 32'h204, 4'b1100, 1'b0, 32'h0, 1);
    exp_cpu(1'b0, 1'b1, 32'h8765_4321, 8'd2);
    cpu_seq(1, 1'b0, 3'b001, 32'h206, 32'h0, 32'h0);

    // illegal accesses: error in the cycle after grant, no memory request
    exp_cpu(1'b1, 1'b0, 32'h0, 8'd1);
    cpu_seq(1, 1'b1, 3'b001, 32'h201, 32'h0, 32'h0000_BEEF);
    exp_mem(1'b1, 32'h200, 4'b1100, 1'b1, 32'hBEEF_BEEF, 1);
    exp_cpu(1'b0, 1'b0, 32'h0, 8'd2);
    cpu_seq(1, 1'b1, 3'b001, 32'h202, 32'h0, 32'h0000_BEEF);
    exp_cpu(1'b1, 1'b0, 32'h0, 8'd1);
    cpu_seq(1, 1'b1, 3'b000, 32'h102, 32'h0, 32'h1111_1111);
    exp_cpu(1'b1, 1'b0, 32'h0, 8'd1);
    cpu_seq(1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0);

    // DMA read with unaligned address, DMA write
    rd_word = 32'hDEAD_BEEF;
    exp_mem(1'b0, 32'h3FC, 4'b1111, 1'b0, 32'h0, 1);
    exp_dma(1'b0, 1'b1, 32'hDEAD_BEEF, 8'd2);
    dma_seq(1, 1'b0, 32'h3FE, 32'h0, 32'h0);
    exp_mem(1'b1, 32'h404, 4'b1111, 1'b1, 32'h55AA_55AA, 1);
    exp_dma(1'b0, 1'b0, 32'h0, 8'd2);
    dma_seq(1, 1'b1, 32'h407, 32'h0, 32'h55AA_55AA);

    // CPU drops its request mid-access; done still pulses
    rd_word = 32'h0BAD_CAFE;
    exp_mem(1'b1, 32'h600, 4'b1111, 1'b1, 32'h600D_600D, 1);
    exp_cpu(1'b0, 1'b1, 32'h0BAD_CAFE, 8'd2);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 3'b000;
    cpu_addr = 32'h600; cpu_wdata = 32'h600D_600D; cpu_start = cyc;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // fairness: both held; order C C C C D C C C C D
    for (int i = 0; i < 4; i++)
      exp_mem(1'b1, 32'h1000 + 32'(4 * i), 4'b1111, 1'b1, 32'hC000_0000 + 32'(i), 1);
    exp_mem(1'b1, 32'h2000, 4'b1111, 1'b1, 32'hD000_0000, 1);
    for (int i = 4; i < 8; i++)
      exp_mem(1'b1, 32'h1000 + 32'(4 * i), 4'b1111, 1'b1, 32'hC000_0000 + 32'(i), 1);
    exp_mem(1'b1, 32'h2004, 4'b1111, 1'b1, 32'hD000_0001, 1);
    for (int i = 0; i < 8; i++) exp_cpu(1'b0, 1'b0, 32'h0, 8'd0);
    for (int i = 0; i < 2; i++) exp_dma(1'b0, 1'b0, 32'h0, 8'd0);
    fork
      cpu_seq(8, 1'b1, 3'b000, 32'h1000, 32'h4, 32'hC000_0000);
      dma_seq(2, 1'b1, 32'h2000, 32'h4, 32'hD000_0000);
    join

    // timeouts: mem_req held 16 cycles, then done with err
    ack_en = 1'b0;
    exp_mem(1'b1, 32'h300, 4'b1111, 1'b1, 32'h7777_7777, 16);
    exp_cpu(1'b1, 1'b0, 32'h0, 8'd17);
    cpu_seq(1, 1'b1, 3'b000, 32'h300, 32'h0, 32'h7777_7777);
    exp_mem(1'b0, 32'h310, 4'b1111, 1'b0, 32'h0, 16);
    exp_dma(1'b1, 1'b0, 32'h0, 8'd17);
    dma_seq(1, 1'b0, 32'h310, 32'h0, 32'h0);

    // reset in BUSY, coinciding with mem_ack: no done, back to IDLE
    exp_mem(1'b1, 32'h500, 4'b1111, 1'b1, 32'h1234_5678, 3);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 3'b000;
    cpu_addr = 32'h500; cpu_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    force_ack = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("post_rst_mem_req", 64'(mem_req), 64'(0));
    check("post_rst_state", 64'(state_dbg), 64'(0));
    check("post_rst_cpu_done", 64'(cpu_done), 64'(0));
    repeat (3) @(posedge clk);
    ack_en = 1'b1;

    // normal operation after reset
    rd_word = 32'h0;
    exp_mem(1'b1, 32'h0, 4'b0010, 1'b1, 32'h5A5A_5A5A, 1);
    exp_cpu(1'b0, 1'b0, 32'h0, 8'd2);
    cpu_seq(1, 1'b1, 3'b010, 32'h001, 32'h0, 32'h0000_005A);

    // every expected response consumed
    repeat (5) @(posedge clk);
    #1;
    check("cpu_exp_left", 64'(cpu_exp_q.size()), 64'(0));
    check("dma_exp_left", 64'(dma_exp_q.size()), 64'(0));
    check("mem_exp_left", 64'(mem_exp_q.size()), 64'(0));
    check("len_exp_left", 64'(len_exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
